// File: rtl/uart_tx_buffered_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// The parity helper takes a zero-extended word so it serves every legal data width.
package uart_pkg;

   localparam int MAX_WIDTH = 16;
   localparam int DEF_DEPTH = 4;
   localparam int CNT_W     = $clog2(DEF_DEPTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Zero-extension leaves the XOR reduction unchanged, so narrower words can share this.
   function automatic logic par_bit(input logic [MAX_WIDTH-1:0] data, input logic typ);
      return (^data) ^ typ;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Write-side valid/ready handshake into the transmitter FIFO.
interface uart_tx_buffered_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] P_DATA;
   logic             DATA_VALID;
   logic             DATA_READY;

   modport master (output P_DATA, output DATA_VALID, input DATA_READY);
   modport slave  (input P_DATA, input DATA_VALID, output DATA_READY);

endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous circular FIFO with first-word fall-through read data.
// Pointers carry one extra MSB so that full and empty can be told apart.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           i_push,
   input  logic [WIDTH-1:0]               i_data,
   input  logic                           i_pop,
   output logic [WIDTH-1:0]               o_data,
   output logic                           o_full,
   output logic                           o_empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign o_empty = (r_wrPtr == r_rdPtr);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rdPtr[AW-1:0]];
   assign o_count = CW'(r_wrPtr - r_rdPtr);

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone decide which entries are valid.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wrPtr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO front end, baud divider and frame FSM.
// TX_OUT and Busy are registered one cycle behind the FSM state, giving a write-to-start-bit latency of two edges.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                        CLK,
   input  logic                        RST,
   uart_tx_buffered_if.slave           wr_if,
   input  logic [PRESCALE_WIDTH-1:0]   Prescale,
   input  logic                        PAR_EN,
   input  logic                        PAR_TYP,
   input  logic                        STP2,
   output logic                        TX_OUT,
   output logic                        Busy,
   output logic [$clog2(DEPTH+1)-1:0]  Fifo_Count
);

   localparam int IDX_W = $clog2(WIDTH);

   tx_state_t                 r_state;
   logic [PRESCALE_WIDTH-1:0] r_baud;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [WIDTH-1:0]          r_shift;
   logic [IDX_W-1:0]          r_bitIdx;
   logic                      r_parEn;
   logic                      r_parBit;
   logic                      r_stp2;
   logic                      r_stop2nd;
   logic                      r_txOut;
   logic                      r_busy;

   logic [WIDTH-1:0]          w_fifoData;
   logic                      w_full;
   logic                      w_empty;
   logic                      w_bitEnd;
   logic                      w_pop;

   uart_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .i_push  (wr_if.DATA_VALID),
      .i_data  (wr_if.P_DATA),
      .i_pop   (w_pop),
      .o_data  (w_fifoData),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (Fifo_Count)
   );

   assign wr_if.DATA_READY = !w_full;
   assign TX_OUT           = r_txOut;
   assign Busy             = r_busy;
   assign w_bitEnd         = (r_baud == '0);

   // A new frame starts from IDLE, or straight out of the final stop bit so queued frames run back to back.
   assign w_pop = !w_empty &&
                  ((r_state == IDLE) ||
                   ((r_state == STOP) && w_bitEnd && (!r_stp2 || r_stop2nd)));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state    <= IDLE;
         r_baud     <= '0;
         r_prescale <= '0;
         r_shift    <= '0;
         r_bitIdx   <= '0;
         r_parEn    <= 1'b0;
         r_parBit   <= 1'b0;
         r_stp2     <= 1'b0;
         r_stop2nd  <= 1'b0;
         r_txOut    <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_busy <= (r_state != IDLE);
         case (r_state)
            START:   r_txOut <= 1'b0;
            DATA:    r_txOut <= r_shift[0];
            PARITY:  r_txOut <= r_parBit;
            default: r_txOut <= 1'b1;
         endcase

         if (w_pop) begin
            r_state    <= START;
            r_shift    <= w_fifoData;
            r_baud     <= Prescale;
            r_prescale <= Prescale;
            r_parEn    <= PAR_EN;
            r_parBit   <= par_bit(MAX_WIDTH'(w_fifoData), PAR_TYP);
            r_stp2     <= STP2;
            r_stop2nd  <= 1'b0;
            r_bitIdx   <= '0;
         end else if (r_state != IDLE) begin
            if (!w_bitEnd) begin
               r_baud <= r_baud - PRESCALE_WIDTH'(1);
            end else begin
               r_baud <= r_prescale;
               case (r_state)
                  START: r_state <= DATA;
                  DATA: begin
                     r_shift <= r_shift >> 1;
                     if (r_bitIdx == IDX_W'(WIDTH - 1)) begin
                        r_bitIdx <= '0;
                        r_state  <= r_parEn ? PARITY : STOP;
                     end else begin
                        r_bitIdx <= r_bitIdx + IDX_W'(1);
                     end
                  end
                  PARITY: r_state <= STOP;
                  STOP: begin
                     if (r_stp2 && !r_stop2nd) r_stop2nd <= 1'b1;
                     else                      r_state   <= IDLE;
                  end
                  default: r_state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered (WIDTH=8, DEPTH=4).
// Expected line patterns are hand-built frames written as {stop, parity, data, start}, read LSB first.
module tb_uart_tx_buffered;

   logic                     clk;
   logic                     rst;
   logic [7:0]               prescale;
   logic                     parEn;
   logic                     parTyp;
   logic                     stp2;
   logic                     txOut;
   logic                     busy;
   logic [uart_pkg::CNT_W-1:0] fifoCount;

   int checkCount = 0;
   int errorCount = 0;

   uart_tx_buffered_if #(.WIDTH(8)) txIf ();

   uart_tx_buffered #(
      .WIDTH          (8),
      .DEPTH          (4),
      .PRESCALE_WIDTH (8)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .wr_if      (txIf),
      .Prescale   (prescale),
      .PAR_EN     (parEn),
      .PAR_TYP    (parTyp),
      .STP2       (stp2),
      .TX_OUT     (txOut),
      .Busy       (busy),
      .Fifo_Count (fifoCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Offers one word for a single edge; the caller is left just after that edge.
   task automatic applyStimulus(input logic [7:0] data);
      txIf.P_DATA     = data;
      txIf.DATA_VALID = 1'b1;
      waitCycle();
      txIf.DATA_VALID = 1'b0;
   endtask

   task automatic checkFrame(input string tag, input logic [15:0] bits, input int nBits,
                             input int period, input int skip);
      for (int j = skip; j < nBits * period; j++) begin
         waitCycle();
         checkOutput({tag, "_tx"}, 32'(txOut), 32'(bits[j / period]));
         checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      end
   endtask

   logic [7:0] words [6];
   int         expCnt [23];
   logic [9:0] f0;
   logic       expTx;

   initial begin
      words  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      expCnt = '{1, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 3, 4};

      rst             = 1'b0;
      txIf.DATA_VALID = 1'b1;
      txIf.P_DATA     = 8'hFF;
      prescale        = 8'd3;
      parEn           = 1'b0;
      parTyp          = 1'b0;
      stp2            = 1'b0;

      $display("[TB] reset with a write offered");
      repeat (3) waitCycle();
      checkOutput("rst_tx", 32'(txOut), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_count", 32'(fifoCount), 32'd0);
      checkOutput("rst_ready", 32'(txIf.DATA_READY), 32'd1);
      txIf.DATA_VALID = 1'b0;
      rst             = 1'b1;
      waitCycle();
      checkOutput("rst_nowrite", 32'(fifoCount), 32'd0);
      checkOutput("rst_idle_tx", 32'(txOut), 32'd1);

      $display("[TB] single frame 0xA5, prescale 3");
      applyStimulus(8'hA5);
      checkOutput("a5_count", 32'(fifoCount), 32'd1);
      waitCycle();
      checkOutput("a5_lat_tx", 32'(txOut), 32'd1);
      checkOutput("a5_lat_busy", 32'(busy), 32'd0);
      checkFrame("a5", 16'({1'b1, 8'hA5, 1'b0}), 10, 4, 0);
      waitCycle();
      checkOutput("a5_end_busy", 32'(busy), 32'd0);
      checkOutput("a5_end_tx", 32'(txOut), 32'd1);

      $display("[TB] parity and stop-bit variants");
      prescale = 8'd1;
      parEn    = 1'b1;
      parTyp   = 1'b0;
      stp2     = 1'b1;
      applyStimulus(8'h03);
      waitCycle();
      checkFrame("par_even", 16'({2'b11, 1'b0, 8'h03, 1'b0}), 12, 2, 0);
      waitCycle();
      checkOutput("par_even_end", 32'(busy), 32'd0);

      parTyp = 1'b1;
      stp2   = 1'b0;
      applyStimulus(8'h03);
      waitCycle();
      parTyp   = 1'b0;
      stp2     = 1'b1;
      parEn    = 1'b0;
      prescale = 8'd0;
      checkFrame("par_odd", 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, 2, 0);
      waitCycle();
      checkOutput("par_odd_end", 32'(busy), 32'd0);

      stp2 = 1'b0;
      applyStimulus(8'h81);
      waitCycle();
      checkFrame("presc0", 16'({1'b1, 8'h81, 1'b0}), 10, 1, 0);
      waitCycle();
      checkOutput("presc0_end", 32'(busy), 32'd0);

      $display("[TB] six words into a four-entry FIFO, valid held high");
      prescale        = 8'd1;
      f0              = {1'b1, words[0], 1'b0};
      txIf.P_DATA     = words[0];
      txIf.DATA_VALID = 1'b1;
      for (int c = 0; c < 23; c++) begin
         waitCycle();
         checkOutput("fifo_count", 32'(fifoCount), 32'(expCnt[c]));
         checkOutput("fifo_ready", 32'(txIf.DATA_READY), 32'(expCnt[c] != 4));
         if (c < 2)        expTx = 1'b1;
         else if (c == 22) expTx = 1'b0;
         else              expTx = f0[(c - 2) / 2];
         checkOutput("fifo_tx", 32'(txOut), 32'(expTx));
         if (c < 5)        txIf.P_DATA = words[c + 1];
         else if (c == 22) txIf.DATA_VALID = 1'b0;
      end
      checkFrame("fifo_f1", 16'({1'b1, words[1], 1'b0}), 10, 2, 1);
      checkFrame("fifo_f2", 16'({1'b1, words[2], 1'b0}), 10, 2, 0);
      checkFrame("fifo_f3", 16'({1'b1, words[3], 1'b0}), 10, 2, 0);
      checkFrame("fifo_f4", 16'({1'b1, words[4], 1'b0}), 10, 2, 0);
      checkFrame("fifo_f5", 16'({1'b1, words[5], 1'b0}), 10, 2, 0);
      waitCycle();
      checkOutput("fifo_end_busy", 32'(busy), 32'd0);
      checkOutput("fifo_end_tx", 32'(txOut), 32'd1);
      checkOutput("fifo_end_count", 32'(fifoCount), 32'd0);

      $display("[TB] reset during the second queued frame");
      prescale        = 8'd3;
      txIf.P_DATA     = 8'hC3;
      txIf.DATA_VALID = 1'b1;
      waitCycle();
      txIf.P_DATA = 8'h3C;
      waitCycle();
      txIf.P_DATA = 8'h5A;
      waitCycle();
      txIf.DATA_VALID = 1'b0;
      checkOutput("mid_count_q", 32'(fifoCount), 32'd2);
      repeat (48) waitCycle();
      checkOutput("mid_busy", 32'(busy), 32'd1);
      checkOutput("mid_count", 32'(fifoCount), 32'd1);
      checkOutput("mid_tx", 32'(txOut), 32'd0);
      rst = 1'b0;
      waitCycle();
      checkOutput("mid_rst_tx", 32'(txOut), 32'd1);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_count", 32'(fifoCount), 32'd0);
      checkOutput("mid_rst_ready", 32'(txIf.DATA_READY), 32'd1);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         waitCycle();
         checkOutput("post_rst_tx", 32'(txOut), 32'd1);
         checkOutput("post_rst_busy", 32'(busy), 32'd0);
      end
      checkOutput("post_rst_count", 32'(fifoCount), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
